// File: rtl/router_pkt_src_if.sv
// router_pkt_src_if: command, payload and router-side signals of the packet source
interface router_pkt_src_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_addr;
    logic [5:0]       cmd_len;
    logic             pay_valid;
    logic             pay_ready;
    logic [7:0]       pay_data;
    logic             busy;
    logic             pkt_valid;
    logic [7:0]       data_out;
    logic             cmd_err;
    logic             pkt_done;
    logic [CNT_W-1:0] pkt_count;
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy,
        output cmd_ready, pay_ready, pkt_valid, data_out, cmd_err, pkt_done, pkt_count
    );
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, pay_valid, pay_data, busy,
        input  cmd_ready, pay_ready, pkt_valid, data_out, cmd_err, pkt_done, pkt_count
    );
endinterface

// File: rtl/router_pkt_src.sv
// router_pkt_src: stages a commanded payload, then replays it as header/payload/parity to the router
module router_pkt_src #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input logic              clock,
    input logic              reset,
    router_pkt_src_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;
    state_t     state, state_n;
    logic [7:0] mem [64];
    logic [1:0] addr, addr_n;
    logic [5:0] len, len_n, fill, fill_n, idx, idx_n;
    logic [7:0] par, par_n, data_n;
    logic [3:0] gap, gap_n;
    logic       wr_en, err_n, done_n, cmd_acc, pay_acc;
    assign cmd_acc = bus.cmd_valid & bus.cmd_ready;
    assign pay_acc = bus.pay_valid & bus.pay_ready;
    // next state and next output values; outputs are registered from these so they track the new state
    always_comb begin
        state_n = state;
        addr_n  = addr;
        len_n   = len;
        fill_n  = fill;
        idx_n   = idx;
        par_n   = par;
        gap_n   = gap;
        wr_en   = 1'b0;
        err_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: if (cmd_acc) begin
                if (bus.cmd_addr == 2'd3 || bus.cmd_len == 6'd0) begin
                    err_n = 1'b1;
                end else begin
                    state_n = LOAD;
                    addr_n  = bus.cmd_addr;
                    len_n   = bus.cmd_len;
                    fill_n  = '0;
                    par_n   = '0;
                end
            end
            LOAD: if (pay_acc) begin
                wr_en  = 1'b1;
                fill_n = fill + 6'd1;
                par_n  = par ^ bus.pay_data;
                if (fill_n == len) state_n = HEADER;
            end
            HEADER: if (!bus.busy) begin
                state_n = PAYLOAD;
                idx_n   = '0;
                par_n   = par ^ {len, addr};
            end
            PAYLOAD: if (!bus.busy) begin
                idx_n = idx + 6'd1;
                if (idx == len - 6'd1) state_n = PARITY;
            end
            PARITY: if (!bus.busy) begin
                state_n = GAP;
                gap_n   = '0;
                done_n  = 1'b1;
            end
            GAP: begin
                gap_n = gap + 4'd1;
                if (gap == 4'(GAP_CYCLES - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        data_n = (state_n == HEADER)  ? {len_n, addr_n} :
                 (state_n == PAYLOAD) ? mem[idx_n] :
                 (state_n == PARITY)  ? par_n : 8'h00;
    end
    // state, bookkeeping and registered outputs; reset drops any staged packet
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            len           <= '0;
            fill          <= '0;
            idx           <= '0;
            par           <= '0;
            gap           <= '0;
            bus.cmd_ready <= 1'b0;
            bus.pay_ready <= 1'b0;
            bus.pkt_valid <= 1'b0;
            bus.data_out  <= 8'h00;
            bus.cmd_err   <= 1'b0;
            bus.pkt_done  <= 1'b0;
            bus.pkt_count <= '0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            len           <= len_n;
            fill          <= fill_n;
            idx           <= idx_n;
            par           <= par_n;
            gap           <= gap_n;
            bus.cmd_ready <= state_n == IDLE;
            bus.pay_ready <= state_n == LOAD;
            bus.pkt_valid <= state_n == HEADER || state_n == PAYLOAD;
            bus.data_out  <= data_n;
            bus.cmd_err   <= err_n;
            bus.pkt_done  <= done_n;
            bus.pkt_count <= bus.pkt_count + CNT_W'(done_n);
        end
    end
    // payload staging buffer; contents need no reset
    always_ff @(posedge clock) begin
        if (wr_en) mem[fill] <= bus.pay_data;
    end
endmodule
